// File: rtl/imm_decode_pkg.sv
// Shared types and constants for the registered RV32I/RV64I immediate decode stage.
`default_nettype none

package imm_decode_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } imm_fmt_e;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;

    // Struct fields are sized for the widest legal configuration; narrower
    // instances use only the low XLEN / TAG_W bits.
    localparam int IMM_MAX_W = 64;
    localparam int TAG_MAX_W = 64;

    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        imm_fmt_e             fmt;
        logic                 illegal;
        logic [TAG_MAX_W-1:0] tag;
    } imm_result_t;

endpackage

`default_nettype wire

// File: rtl/imm_decode_stage_if.sv
// Valid/ready bus between fetch, the immediate decode stage and execute.
`default_nettype none

interface imm_decode_stage_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    import imm_decode_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    imm_fmt_e         out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    // slave: the decode stage itself
    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

    // master: the surrounding pipeline (fetch side drives, execute side consumes)
    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

endinterface

`default_nettype wire

// File: rtl/imm_select.sv
// Combinational opcode decode and immediate extraction, sign-extended to XLEN.
`default_nettype none

module imm_select
    import imm_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic [31:0]     instr,
    output logic     [XLEN-1:0] imm,
    output imm_fmt_e            fmt,
    output logic                illegal
);

    localparam bit RV64 = (XLEN == 64);

    logic [31:0] imm32;

    always_comb begin
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (instr[6:0])
            OPC_LUI, OPC_AUIPC:                        fmt = FMT_U;
            OPC_JAL:                                   fmt = FMT_J;
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_SYSTEM: fmt = FMT_I;
            OPC_STORE:                                 fmt = FMT_S;
            OPC_BRANCH:                                fmt = FMT_B;
            OPC_OP:                                    fmt = FMT_R;
            // *-32 word ops only exist on RV64; on RV32 they are unknown opcodes
            OPC_OPIMM32: begin
                fmt     = RV64 ? FMT_I : FMT_NONE;
                illegal = !RV64;
            end
            OPC_OP32: begin
                fmt     = RV64 ? FMT_R : FMT_NONE;
                illegal = !RV64;
            end
            default:                                   illegal = 1'b1;
        endcase
    end

    always_comb begin
        imm32 = 32'd0;
        case (fmt)
            FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'd0};
            FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

`default_nettype wire

// File: rtl/imm_decode_stage.sv
// Registered immediate decode stage: decode on input, output register plus skid
// register so in_ready never depends combinationally on out_ready.
`default_nettype none

module imm_decode_stage
    import imm_decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         flush,
    imm_decode_stage_if.slave bus
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    state_e          state;
    imm_result_t     or_q;
    imm_result_t     sk_q;
    logic            in_ready_q;
    logic            out_valid_q;

    logic [XLEN-1:0] sel_imm;
    imm_fmt_e        sel_fmt;
    logic            sel_illegal;
    imm_result_t     dec;
    logic            take_in;
    logic            take_out;

    imm_select #(.XLEN(XLEN)) u_imm_select (
        .instr   (bus.in_instr),
        .imm     (sel_imm),
        .fmt     (sel_fmt),
        .illegal (sel_illegal)
    );

    always_comb begin
        dec                  = '0;
        dec.imm[XLEN-1:0]    = sel_imm;
        dec.fmt              = sel_fmt;
        dec.illegal          = sel_illegal;
        dec.tag[TAG_W-1:0]   = bus.in_tag;
    end

    assign take_in  = bus.in_valid & in_ready_q;
    assign take_out = out_valid_q & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_EMPTY;
            or_q        <= '0;
            sk_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state       <= S_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (take_in) begin
                        or_q        <= dec;
                        out_valid_q <= 1'b1;
                        state       <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (take_in && !take_out) begin
                        sk_q       <= dec;
                        in_ready_q <= 1'b0;
                        state      <= S_FULL;
                    end else if (take_in && take_out) begin
                        or_q <= dec;
                    end else if (take_out) begin
                        out_valid_q <= 1'b0;
                        state       <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    // in_ready is low here, so only the drain direction can fire
                    if (take_out) begin
                        or_q       <= sk_q;
                        in_ready_q <= 1'b1;
                        state      <= S_ONE;
                    end
                end
                default: begin
                    state       <= S_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_imm     = or_q.imm[XLEN-1:0];
    assign bus.out_fmt     = or_q.fmt;
    assign bus.out_illegal = or_q.illegal;
    assign bus.out_tag     = or_q.tag[TAG_W-1:0];

    // Upper struct bits beyond XLEN/TAG_W are constant zero and intentionally dropped.
    logic unused_hi;
    assign unused_hi = ^{or_q.imm, or_q.tag};

endmodule

`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: an RV32 instance checked in full, plus an
// RV64 instance fed the same stream for the XLEN-dependent results.
`default_nettype none

module tb_imm_decode_stage;
    import imm_decode_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    imm_decode_stage_if #(.XLEN(32), .TAG_W(32)) bus32 ();
    imm_decode_stage_if #(.XLEN(64), .TAG_W(32)) bus64 ();

    imm_decode_stage #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus32.slave)
    );

    imm_decode_stage #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus64.slave)
    );

    assign bus64.in_valid  = bus32.in_valid;
    assign bus64.in_instr  = bus32.in_instr;
    assign bus64.in_tag    = bus32.in_tag;
    assign bus64.out_ready = bus32.out_ready;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] tag);
        bus32.in_valid = v;
        bus32.in_instr = instr;
        bus32.in_tag   = tag;
    endtask

    task automatic check_out32(input string tag, input logic [31:0] imm, input imm_fmt_e fmt,
                               input logic ill, input logic [31:0] t);
        check({tag, ".valid"}, 64'(bus32.out_valid),   64'd1);
        check({tag, ".imm"},   64'(bus32.out_imm),     64'(imm));
        check({tag, ".fmt"},   64'(bus32.out_fmt),     64'(fmt));
        check({tag, ".ill"},   64'(bus32.out_illegal), 64'(ill));
        check({tag, ".tag"},   64'(bus32.out_tag),     64'(t));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".valid"}, 64'(bus32.out_valid),   64'd0);
        check({tag, ".imm"},   64'(bus32.out_imm),     64'd0);
        check({tag, ".fmt"},   64'(bus32.out_fmt),     64'(FMT_NONE));
        check({tag, ".ill"},   64'(bus32.out_illegal), 64'd0);
        check({tag, ".tag"},   64'(bus32.out_tag),     64'd0);
        check({tag, ".rdy"},   64'(bus32.in_ready),    64'd1);
        check({tag, ".v64"},   64'(bus64.out_valid),   64'd0);
    endtask

    initial begin
        drive(1'b0, 32'd0, 32'd0);
        bus32.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check_reset_vals("rst0");
        #9 rst_n = 1'b1;

        // addi x1,x0,-1 then a back-to-back stream with out_ready held high
        bus32.out_ready = 1'b1;
        drive(1'b1, 32'hFFF00093, 32'hA0);
        step();
        check_out32("addi", 32'hFFFFFFFF, FMT_I, 1'b0, 32'hA0);
        check("addi.imm64", bus64.out_imm, 64'hFFFFFFFFFFFFFFFF);

        drive(1'b1, 32'hFE112E23, 32'h1);
        step();
        check_out32("sw", 32'hFFFFFFFC, FMT_S, 1'b0, 32'h1);
        check("sw.imm64", bus64.out_imm, 64'hFFFFFFFFFFFFFFFC);
        drive(1'b1, 32'hFE000CE3, 32'h2);
        step();
        check_out32("beq", 32'hFFFFFFF8, FMT_B, 1'b0, 32'h2);
        drive(1'b1, 32'h123452B7, 32'h3);
        step();
        check_out32("lui", 32'h12345000, FMT_U, 1'b0, 32'h3);
        drive(1'b1, 32'h0010006F, 32'h4);
        step();
        check_out32("jal", 32'h00000800, FMT_J, 1'b0, 32'h4);
        drive(1'b1, 32'h00000033, 32'h5);
        step();
        check_out32("op", 32'h0, FMT_R, 1'b0, 32'h5);

        // unknown opcode and RV64-only opcode
        drive(1'b1, 32'h0000007F, 32'h6);
        step();
        check_out32("bad", 32'h0, FMT_NONE, 1'b1, 32'h6);
        drive(1'b1, 32'h0000001B, 32'h7);
        step();
        check_out32("opimm32", 32'h0, FMT_NONE, 1'b1, 32'h7);
        check("opimm32.ill64", 64'(bus64.out_illegal), 64'd0);
        check("opimm32.fmt64", 64'(bus64.out_fmt), 64'(FMT_I));

        drive(1'b0, 32'd0, 32'd0);
        step();
        check("drain.valid", 64'(bus32.out_valid), 64'd0);

        // back-pressure: beats 1 and 2 fill OR/SK, beat 3 is held off
        bus32.out_ready = 1'b0;
        drive(1'b1, 32'h00000013, 32'h11);
        step();
        check("bp1.tag", 64'(bus32.out_tag), 64'h11);
        check("bp1.rdy", 64'(bus32.in_ready), 64'd1);
        drive(1'b1, 32'h00000013, 32'h12);
        step();
        check("bp2.rdy", 64'(bus32.in_ready), 64'd0);
        check("bp2.tag", 64'(bus32.out_tag), 64'h11);
        drive(1'b1, 32'h00000013, 32'h13);
        step();
        check("bp3.rdy", 64'(bus32.in_ready), 64'd0);
        check("bp3.hold", 64'(bus32.out_tag), 64'h11);
        bus32.out_ready = 1'b1;
        step();
        check("rel2.tag", 64'(bus32.out_tag), 64'h12);
        check("rel2.rdy", 64'(bus32.in_ready), 64'd1);
        step();
        check("rel3.tag", 64'(bus32.out_tag), 64'h13);
        check("rel3.valid", 64'(bus32.out_valid), 64'd1);
        drive(1'b0, 32'd0, 32'd0);
        step();
        check("rel.empty", 64'(bus32.out_valid), 64'd0);

        // flush while FULL with an input presented
        bus32.out_ready = 1'b0;
        drive(1'b1, 32'h00000013, 32'h21);
        step();
        drive(1'b1, 32'h00000013, 32'h22);
        step();
        flush = 1'b1;
        drive(1'b1, 32'h00000013, 32'h99);
        step();
        check("flF.valid", 64'(bus32.out_valid), 64'd0);
        check("flF.rdy", 64'(bus32.in_ready), 64'd1);
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        bus32.out_ready = 1'b1;
        step();
        check("flF.after", 64'(bus32.out_valid), 64'd0);

        // flush in ONE where the simultaneous beat would otherwise be accepted
        bus32.out_ready = 1'b0;
        drive(1'b1, 32'h00000013, 32'h31);
        step();
        flush = 1'b1;
        drive(1'b1, 32'h00000013, 32'h32);
        step();
        check("fl1.valid", 64'(bus32.out_valid), 64'd0);
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        step();
        check("fl1.after", 64'(bus32.out_valid), 64'd0);

        // asynchronous reset between edges while FULL
        drive(1'b1, 32'hFFF00093, 32'h41);
        step();
        drive(1'b1, 32'hFFF00093, 32'h42);
        step();
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        drive(1'b0, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus32.out_ready = 1'b1;
        drive(1'b1, 32'h123452B7, 32'h51);
        step();
        check_out32("post", 32'h12345000, FMT_U, 1'b0, 32'h51);
        drive(1'b0, 32'd0, 32'd0);
        step();
        check("post.empty", 64'(bus32.out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Parametrised, registered successor to the combinational immediate generator.
- Decodes the RV32I/RV64I opcode and selects one immediate (I/S/B/U/J). Sign-extends it to XLEN and presents it with a format code and a pass-through tag.
- Sits between fetch and execute as one valid/ready pipeline stage with a skid buffer, so fetch never sees a combinational ready path from execute.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64; immediates sign-extend to XLEN.
- TAG_W, 32, width of the opaque tag carried alongside the instruction (normally the PC).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous pipeline flush.
- in_valid  input  1  instruction presented.
- in_ready  output  1  stage can accept; driven from a register only.
- in_instr  input  32  raw instruction.
- in_tag  input  TAG_W  tag.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts.
- out_imm  output  XLEN  selected, sign-extended immediate.
- out_fmt  output  3  format code (imm_fmt_e).
- out_illegal  output  1  opcode not recognised.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- Opcode[6:0] to format mapping:
  - 0110111 LUI and 0010111 AUIPC: U.
  - 1101111 JAL: J.
  - 1100111 JALR, 0000011 LOAD, 0010011 OP-IMM, 1110011 SYSTEM: I.
  - 0011011 OP-IMM-32: I, legal only when XLEN=64.
  - 0100011 STORE: S.
  - 1100011 BRANCH: B.
  - 0110011 OP: R (imm 0).
  - 0111011 OP-32: R, legal only when XLEN=64.
  - Anything else: NONE, imm 0, illegal=1.
- Immediate fields, all sign-extended from instr[31] to XLEN:
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U = {instr[31:12], 12'b0}.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Latency: a beat accepted at edge N is visible on out_* after edge N (1 cycle) when the output register is free.
- Storage: output register (OR) plus one skid register (SK).
- States:
  - EMPTY: OR invalid.
  - ONE: OR valid, SK empty.
  - FULL: OR and SK valid.
- Handshakes: transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
- in_ready = !SK_valid (registered).
- Transitions:
  - EMPTY + in → ONE.
  - ONE + in & !out → FULL; the input beat goes to SK.
  - ONE + in & out → ONE; OR is reloaded.
  - ONE + out & !in → EMPTY.
  - FULL + out → ONE; SK moves to OR. No input is possible in FULL since in_ready=0.
- Ordering: strictly FIFO; no beat is dropped or duplicated.
- out_* hold stable while out_valid & !out_ready.
- flush: clears both valids at the next edge and overrides any simultaneous input; that beat is discarded. in_ready is 1 the cycle after.
- Reset: asserted at any time, including mid-transfer, immediately forces out_valid=0, out_imm=0, out_fmt=NONE, out_illegal=0, out_tag=0, SK empty. in_ready=1 after release.
- Decoding is done on the input side before registering. SK stores the decoded result, not the raw instruction.

Decomposition:
- Package imm_decode_pkg holds:
  - typedef enum logic [2:0] imm_fmt_e {FMT_NONE=0, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J}.
  - localparam opcode constants (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_SYSTEM, OPC_OPIMM32, OPC_OP32).
  - Packed struct imm_result_t {imm, fmt, illegal, tag}.
- One combinational sub-module, imm_select, maps instr to {imm, fmt, illegal} for a given XLEN.
- The top module owns the OR/SK pipeline.

Test Plan:
- 0xFFF00093 (addi x1,x0,-1), out_ready=1 → next cycle out_imm=0xFFFFFFFF, fmt=I, illegal=0; with XLEN=64, imm=0xFFFFFFFFFFFFFFFF.
- Back-to-back stream with out_ready=1, one beat per cycle:
  - 0xFE112E23 (sw -4) → S, 0xFFFFFFFC.
  - 0xFE000CE3 (beq -8) → B, 0xFFFFFFF8.
  - 0x123452B7 (lui) → U, 0x12345000.
  - 0x0010006F (jal +2048) → J, 0x00000800.
- out_ready=0, push three beats with tags 1, 2, 3 → tags 1 and 2 accepted, in_ready=0 while tag 3 is held. Release → outputs 1, 2, 3 in order on consecutive cycles, no loss.
- Illegal/RV32 check with XLEN=32: 0x0000007F → fmt=NONE, imm=0, illegal=1. 0x0000001B (OP-IMM-32) → illegal=1.
- flush in FULL state with simultaneous in_valid → next cycle out_valid=0, in_ready=1, flushed input never appears on out_*.
- rst_n pulled low mid-stream between clock edges → out_valid=0 immediately (asynchronous), all outputs at reset values. After release the first accepted beat emerges 1 cycle later.
